alu_sched: RTL

//  Round-robin scheduler sharing one 64-bit ALU between NREQ requesters.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 44 ++++
 rtl/alu_sched.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared types for the ALU scheduler slice.
//   alu_op_t      : ALUControl encodings understood by the external 64-bit alu.
//                   The scheduler passes all codes through without decoding them.
//   sched_state_t : scheduler FSM state, also exported as a debug output.
//   next_rr       : round-robin pointer successor with wrap at nreq-1.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND   = 4'b0000,
        ALU_OR    = 4'b0001,
        ALU_ADD   = 4'b0010,
        ALU_SUB   = 4'b0110,
        ALU_PASSB = 4'b0111,
        ALU_NOR   = 4'b1100
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } sched_state_t;

    // Successor of a grant index, wrapping to 0 after the last requester.
    function automatic int next_rr(input int idx, input int nreq);
        return (idx >= nreq - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Purely combinational round-robin pick: starting at ptr_i and wrapping,
//   returns the first requester with req_i set.
// Ports
//   req_i  in   NREQ  request vector
//   ptr_i  in   PW    highest-priority index this round
//   gnt_o  out  NREQ  one-hot grant (0 when no request)
//   idx_o  out  PW    index of the granted requester (0 when no request)
//   any_o  out  1     at least one request present
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [PW-1:0]   idx_o,
    output logic            any_o
);

    always_comb begin
        int          c;
        logic [PW-1:0] cidx;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        c     = 0;
        cidx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            // Candidate index (ptr + k) mod NREQ without a divider.
            c = int'(ptr_i) + k;
            if (c >= NREQ) begin
                c = c - NREQ;
            end
            cidx = PW'(c);
            if (!any_o && req_i[cidx]) begin
                any_o       = 1'b1;
                gnt_o[cidx] = 1'b1;
                idx_o       = cidx;
            end
        end
    end

endmodule

// File: rtl/alu_sched.sv
// alu_sched
//   Round-robin scheduler sharing one external ALU between NREQ requesters.
//   One operation is in flight at a time: IDLE -> ISSUE -> RESP -> (IDLE | ISSUE).
//   Operands are latched on accept and held on alu_* in every state; the alu
//   result is captured at the end of ISSUE and returned to the owner in RESP.
//
//   Handshake rule (both directions): a transfer happens on a rising edge where
//   valid and ready are both high for the same requester index. req_ready is
//   combinational and one-hot (or 0); resp_valid is registered and one-hot (or 0).
//   req_valid may be withdrawn at any time; data is sampled only in the
//   cycle req_ready is high. A returning result and a new accept can share a cycle.
//
// Ports
//   clk, reset                 clock, async active-high reset
//   req_valid/req_ready        per-requester op handshake
//   req_a/req_b/req_ctrl       packed per-requester operands and ALUControl
//   resp_valid/resp_ready      per-requester result handshake
//   resp_result/resp_zero      registered result and zero flag (shared bus)
//   alu_a/alu_b/alu_ctrl       to external alu
//   alu_result/alu_zero        from external alu (combinational)
//   busy                       scheduler not idle
//   dbg_state                  current FSM state (sched_state_t encoding)
module alu_sched
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int W    = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ*4-1:0] req_ctrl,
    output logic [NREQ-1:0]   resp_valid,
    input  logic [NREQ-1:0]   resp_ready,
    output logic [W-1:0]      resp_result,
    output logic              resp_zero,
    output logic [W-1:0]      alu_a,
    output logic [W-1:0]      alu_b,
    output logic [3:0]        alu_ctrl,
    input  logic [W-1:0]      alu_result,
    input  logic              alu_zero,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam int PW = $clog2(NREQ);

    sched_state_t      state_q;
    logic [W-1:0]      a_q, b_q, res_q;
    logic [3:0]        ctrl_q;
    logic              zero_q;
    logic [PW-1:0]     rr_q, owner_q;
    logic [NREQ-1:0]   resp_valid_q;
    logic              busy_q;

    logic [NREQ-1:0]   arb_gnt;
    logic [PW-1:0]     arb_idx;
    logic              arb_any;

    logic              resp_hs;
    logic              accept_en;
    logic              grant;
    logic [W-1:0]      a_d, b_d;
    logic [3:0]        ctrl_d;
    logic [PW-1:0]     rr_d;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req_i (req_valid),
        .ptr_i (rr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    // Result leaves when the owner takes it; other requesters' resp_ready is ignored.
    assign resp_hs   = (state_q == RESP) && resp_ready[owner_q];
    // A new op may be accepted from IDLE or in the same cycle the result is returned.
    assign accept_en = (state_q == IDLE) || resp_hs;
    // Reset also gates the combinational ready so nothing appears accepted during reset.
    assign grant     = accept_en && arb_any && !reset;
    assign req_ready = grant ? arb_gnt : '0;

    assign a_d    = req_a[int'(arb_idx)*W +: W];
    assign b_d    = req_b[int'(arb_idx)*W +: W];
    assign ctrl_d = req_ctrl[int'(arb_idx)*4 +: 4];
    assign rr_d   = PW'(next_rr(int'(arb_idx), NREQ));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            ctrl_q       <= '0;
            res_q        <= '0;
            zero_q       <= 1'b0;
            rr_q         <= '0;
            owner_q      <= '0;
            resp_valid_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            // grant is only ever true in IDLE or on a RESP handshake.
            if (grant) begin
                a_q     <= a_d;
                b_q     <= b_d;
                ctrl_q  <= ctrl_d;
                owner_q <= arb_idx;
                rr_q    <= rr_d;
            end
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        state_q <= ISSUE;
                        busy_q  <= 1'b1;
                    end
                end
                ISSUE: begin
                    res_q        <= alu_result;
                    zero_q       <= alu_zero;
                    resp_valid_q <= NREQ'(1) << owner_q;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (resp_hs) begin
                        resp_valid_q <= '0;
                        if (grant) begin
                            state_q <= ISSUE;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_result = res_q;
    assign resp_zero   = zero_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_ctrl    = ctrl_q;
    assign busy        = busy_q;
    assign dbg_state   = state_q;

endmodule
